f5_sweep_checker: RTL



---
 rtl/f5_sweep_checker_if.sv | 24 ++
 rtl/f5_sweep_checker.sv | 95 +++++++++
 2 files changed

// File: rtl/f5_sweep_checker_if.sv
// Handshake/result bundle between the f5 sweep checker and the function it exercises.
// The master modport is the checker; the slave modport is the function/bench side.
interface f5_sweep_checker_if #(
  parameter int N_IN = 2
);
  logic                 start;
  logic [N_IN-1:0]      vec_out;
  logic                 s_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic [2**N_IN-1:0]   observed;

  modport master (
    input  start, s_in,
    output vec_out, busy, done, pass, err_count, observed
  );

  modport slave (
    output start, s_in,
    input  vec_out, busy, done, pass, err_count, observed
  );
endinterface

// File: rtl/f5_sweep_checker.sv
// Sweeps every input pattern of f5 (s = ~a & b), samples s after a settle delay and
// compares it against the expected truth table, reporting pass, mismatch count and observed table.
module f5_sweep_checker #(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b0010
) (
  input  logic                clk,
  input  logic                rst_n,
  f5_sweep_checker_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

  state_t               state_q, state_d;
  logic [N_IN-1:0]      vec_q, vec_d;
  logic [3:0]           wait_q, wait_d;
  logic [N_IN:0]        err_q, err_d;
  logic [2**N_IN-1:0]   obs_q, obs_d;
  logic                 pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      obs_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      obs_q   <= obs_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    obs_d   = obs_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          vec_d   = '0;
          wait_d  = SETTLE_W;
          err_d   = '0;
          obs_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          obs_d[vec_q] = bus.s_in;
          if (bus.s_in != EXPECT[vec_q]) begin
            err_d = err_q + ERR_ONE;
          end
          // pass must reflect the mismatch found on the final pattern, hence err_d
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            vec_d  = vec_q + VEC_ONE;
            wait_d = SETTLE_W;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.vec_out   = vec_q;
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
    bus.pass      = pass_q;
    bus.err_count = err_q;
    bus.observed  = obs_q;
  end

endmodule
